vga_pattern_gen: RTL and testbench

- Parametrised frame-pattern source that writes one full frame of pixels into the SDRAM write path, under control of the downstream write-enable.
- Successor to the fixed 1024x768 counter generator. Adds:
  - configurable data width and geometry;
  - four selectable patterns;
  - continuous multi-frame mode with graceful stop;
  - frame markers and a frame counter.
- Sits between the control/start logic and the SDRAM write FIFO in the SDRAM-VGA experiment.

---
 rtl/vga_pattern_gen.sv | 200 ++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// Frame-pattern source feeding the SDRAM write path. It emits one frame (or a
// continuous run of frames) of H_ACTIVE x V_ACTIVE pixels, one pixel per cycle
// while wr_en is high, with frame markers and a completed-frame counter.
module vga_pattern_gen #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned H_ACTIVE    = 1024,
    parameter int unsigned V_ACTIVE    = 768,
    parameter int unsigned SPAN_NUM    = 1,
    parameter int unsigned CHECK_SHIFT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic              continuous_i,
    input  logic              stop_i,
    input  logic              wr_en,
    output logic              data_en,
    output logic [DATA_W-1:0] dout,
    output logic              sof_o,
    output logic              eof_o,
    output logic              busy_o,
    output logic [7:0]        frame_cnt_o
);

    // Position counters are widened so the checker bit index always exists.
    localparam int unsigned X_W = ($clog2(H_ACTIVE) > CHECK_SHIFT + 1) ? $clog2(H_ACTIVE) : CHECK_SHIFT + 1;
    localparam int unsigned Y_W = ($clog2(V_ACTIVE) > CHECK_SHIFT + 1) ? $clog2(V_ACTIVE) : CHECK_SHIFT + 1;
    localparam int unsigned BAR_W     = H_ACTIVE / 8;
    localparam int unsigned BAR_SHIFT = (DATA_W < 16) ? 16 - DATA_W : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        sync_q, sync_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [DATA_W-1:0] lin_q, lin_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [1:0]        mode_q, mode_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              stop_pending_q, stop_pending_d;
    logic              sof_done_q, sof_done_d;
    logic              data_en_q, data_en_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              busy_q, busy_d;

    logic              start_pulse_c;
    logic              last_c;
    logic [2:0]        bar_idx_c;
    logic [15:0]       colour_c;
    logic              chk_bit_c;
    logic [DATA_W-1:0] pixel_c;

    assign sync_d        = {sync_q[1:0], start_i};
    assign start_pulse_c = sync_q[1] & ~sync_q[2];
    assign last_c        = (x_q == X_W'(H_ACTIVE - 1)) && (y_q == Y_W'(V_ACTIVE - 1));

    // Pixel value for the current position under the latched pattern.
    always_comb begin
        bar_idx_c = 3'(x_q / X_W'(BAR_W));
        case (bar_idx_c)
            3'd0:    colour_c = 16'hFFFF;
            3'd1:    colour_c = 16'hFFE0;
            3'd2:    colour_c = 16'h07FF;
            3'd3:    colour_c = 16'h07E0;
            3'd4:    colour_c = 16'hF81F;
            3'd5:    colour_c = 16'hF800;
            3'd6:    colour_c = 16'h001F;
            default: colour_c = 16'h0000;
        endcase
        chk_bit_c = x_q[CHECK_SHIFT] ^ y_q[CHECK_SHIFT] ^ seed_q[0];
        case (mode_q)
            2'd0:    pixel_c = seed_q + lin_q;
            2'd1:    pixel_c = DATA_W'(colour_c >> BAR_SHIFT);
            2'd2:    pixel_c = {DATA_W{chk_bit_c}};
            default: pixel_c = seed_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_pulse_c) state_d = S_PRE;
            S_PRE:   state_d = S_WRITE;
            S_WRITE: if (wr_en && last_c) state_d = S_DONE;
            S_DONE:  state_d = (continuous_i && !stop_pending_q) ? S_PRE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        x_d            = x_q;
        y_d            = y_q;
        lin_d          = lin_q;
        seed_d         = seed_q;
        mode_d         = mode_q;
        frame_cnt_d    = frame_cnt_q;
        stop_pending_d = stop_pending_q;
        sof_done_d     = sof_done_q;
        data_en_d      = 1'b0;
        dout_d         = dout_q;
        sof_d          = 1'b0;
        eof_d          = 1'b0;
        busy_d         = (state_d != S_IDLE);

        if (state_q != S_IDLE && stop_i) stop_pending_d = 1'b1;

        case (state_q)
            S_PRE: begin
                mode_d     = mode_i;
                x_d        = '0;
                y_d        = '0;
                lin_d      = '0;
                sof_done_d = 1'b0;
            end
            S_WRITE: begin
                if (wr_en) begin
                    data_en_d  = 1'b1;
                    dout_d     = pixel_c;
                    sof_d      = !sof_done_q;
                    eof_d      = last_c;
                    sof_done_d = 1'b1;
                    lin_d      = lin_q + DATA_W'(1);
                    if (x_q == X_W'(H_ACTIVE - 1)) begin
                        x_d = '0;
                        y_d = y_q + Y_W'(1);
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
            end
            S_DONE: begin
                seed_d      = seed_q + DATA_W'(SPAN_NUM);
                frame_cnt_d = frame_cnt_q + 8'd1;
                if (!(continuous_i && !stop_pending_q)) stop_pending_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q         <= '0;
            x_q            <= '0;
            y_q            <= '0;
            lin_q          <= '0;
            seed_q         <= '0;
            mode_q         <= '0;
            frame_cnt_q    <= '0;
            stop_pending_q <= 1'b0;
            sof_done_q     <= 1'b0;
            data_en_q      <= 1'b0;
            dout_q         <= '0;
            sof_q          <= 1'b0;
            eof_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            x_q            <= x_d;
            y_q            <= y_d;
            lin_q          <= lin_d;
            seed_q         <= seed_d;
            mode_q         <= mode_d;
            frame_cnt_q    <= frame_cnt_d;
            stop_pending_q <= stop_pending_d;
            sof_done_q     <= sof_done_d;
            data_en_q      <= data_en_d;
            dout_q         <= dout_d;
            sof_q          <= sof_d;
            eof_q          <= eof_d;
            busy_q         <= busy_d;
        end
    end

    assign data_en     = data_en_q;
    assign dout        = dout_q;
    assign sof_o       = sof_q;
    assign eof_o       = eof_q;
    assign busy_o      = busy_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a 16x4 frame with 16-bit pixels.
module tb_vga_pattern_gen;

    localparam int unsigned DW   = 16;
    localparam int unsigned H    = 16;
    localparam int unsigned V    = 4;
    localparam int unsigned CS   = 1;
    localparam int unsigned NPIX = H * V;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [1:0]    mode_i;
    logic          continuous_i;
    logic          stop_i;
    logic          wr_en;
    logic          data_en;
    logic [DW-1:0] dout;
    logic          sof_o;
    logic          eof_o;
    logic          busy_o;
    logic [7:0]    frame_cnt_o;

    vga_pattern_gen #(
        .DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .SPAN_NUM(1), .CHECK_SHIFT(CS)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
        .continuous_i(continuous_i), .stop_i(stop_i), .wr_en(wr_en),
        .data_en(data_en), .dout(dout), .sof_o(sof_o), .eof_o(eof_o),
        .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   seed_m = 0;
    int   frames_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [15:0] bar_colour(input int idx);
        case (idx)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Reference pixel k of a frame, straight from the pattern definitions.
    function automatic logic [15:0] model_pixel(input int mode, input int seed, input int k);
        int x;
        int y;
        x = k % H;
        y = k / H;
        case (mode)
            0:       return 16'(seed + k);
            1:       return bar_colour(x / (H / 8));
            2:       return ((((x >> CS) ^ (y >> CS) ^ seed) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: return 16'(seed);
        endcase
    endfunction

    task automatic push_frame(input int mode, input int seed);
        exp_t e;
        for (int k = 0; k < NPIX; k++) begin
            e.d   = model_pixel(mode, seed, k);
            e.sof = (k == 0);
            e.eof = (k == NPIX - 1);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every presented pixel is popped and compared; markers need data_en.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got dout %0h, expected no pixel", dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pixel_dout", 32'(dout), 32'(mon_e.d));
                    chk("pixel_sof", 32'(sof_o), 32'(mon_e.sof));
                    chk("pixel_eof", 32'(eof_o), 32'(mon_e.eof));
                end
            end else begin
                chk("marker_without_data_en", 32'({sof_o, eof_o}), 32'(0));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst          = 1'b1;
        start_i      = 1'b0;
        stop_i       = 1'b0;
        wr_en        = 1'b0;
        continuous_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        seed_m   = 0;
        frames_m = 0;
    endtask

    task automatic check_reset;
        @(negedge clk);
        chk("reset_data_en", 32'(data_en), 32'(0));
        chk("reset_dout", 32'(dout), 32'(0));
        chk("reset_sof_eof", 32'({sof_o, eof_o}), 32'(0));
        chk("reset_busy", 32'(busy_o), 32'(0));
        chk("reset_frame_cnt", 32'(frame_cnt_o), 32'(0));
    endtask

    // Raise start_i; busy must appear on the third edge after it.
    task automatic start_frame;
        start_i = 1'b1;
        tick();
        tick();
        chk("busy_before_sync", 32'(busy_o), 32'(0));
        tick();
        chk("busy_rise", 32'(busy_o), 32'(1));
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s: timeout, busy %0d, %0d pixels outstanding, expected idle and 0", nm, busy_o, exp_q.size());
        end
    endtask

    // One frame; kind 0 = wr_en always high, 1 = toggling, 2 = random.
    task automatic run_frame(input int mode, input int kind);
        int   acc;
        int   it;
        logic w;
        mode_i = 2'(mode);
        push_frame(mode, seed_m);
        start_frame();
        wr_en = 1'b0;
        tick();
        mode_i = 2'($urandom_range(0, 3));
        acc = 0;
        it  = 0;
        while (acc < NPIX && it < 1000) begin
            if (kind == 0)      w = 1'b1;
            else if (kind == 1) w = (it % 2 == 0);
            else                w = 1'($urandom_range(0, 1));
            wr_en = w;
            tick();
            if (w) acc++;
            @(negedge clk);
            chk("data_en_follows_wr_en", 32'(data_en), 32'(w));
            it++;
        end
        checks++;
        if (acc < NPIX) begin
            errors++;
            $display("FAIL frame_accept: got %0d pixels accepted, expected %0d", acc, NPIX);
        end
        wr_en = 1'b1;
        wait_idle("frame_end");
        seed_m++;
        frames_m++;
        chk("frame_cnt", 32'(frame_cnt_o), 32'(frames_m));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int gap;
        int it;
        int acc;
        mode_i = 2'd0;
        do_reset();
        check_reset();

        // INCR frames: seed 0 then seed 1, the second under toggling backpressure.
        run_frame(0, 0);
        run_frame(0, 1);
        run_frame(1, 2);

        // Checker from seed 0, then seed 1 (inverted) with random backpressure.
        do_reset();
        check_reset();
        run_frame(2, 0);
        run_frame(2, 2);

        // Continuous SOLID frames; stop_i in IDLE is ignored, stop in frame 2 ends the run.
        do_reset();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        repeat (4) tick();
        continuous_i = 1'b1;
        mode_i       = 2'd3;
        wr_en        = 1'b1;
        push_frame(3, 0);
        push_frame(3, 1);
        start_frame();
        n   = 0;
        gap = 0;
        it  = 0;
        while (n < 2 * NPIX && it < 1000) begin
            @(negedge clk);
            it++;
            if (data_en) n++;
            else if (n == NPIX) gap++;
            stop_i = (n == NPIX + 20);
        end
        stop_i = 1'b0;
        chk("continuous_pixel_count", 32'(n), 32'(2 * NPIX));
        chk("dead_cycles", 32'(gap), 32'(2));
        wait_idle("continuous_end");
        repeat (10) tick();
        chk("continuous_stopped_busy", 32'(busy_o), 32'(0));
        chk("continuous_frame_cnt", 32'(frame_cnt_o), 32'(2));
        continuous_i = 1'b0;
        seed_m   = 2;
        frames_m = 2;

        // A start edge while busy is ignored.
        mode_i = 2'd0;
        push_frame(0, seed_m);
        start_frame();
        repeat (10) tick();
        start_i = 1'b1;
        repeat (6) tick();
        start_i = 1'b0;
        wait_idle("ignored_start");
        seed_m++;
        frames_m++;
        repeat (20) tick();
        chk("ignored_start_busy", 32'(busy_o), 32'(0));
        chk("ignored_start_frame_cnt", 32'(frame_cnt_o), 32'(frames_m));

        // Reset mid-frame after 20 pixels, then a clean restart.
        mode_i = 2'd0;
        push_frame(0, seed_m);
        start_frame();
        wr_en = 1'b0;
        tick();
        wr_en = 1'b1;
        acc = 0;
        while (acc < 20) begin
            tick();
            acc++;
            @(negedge clk);
        end
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        seed_m   = 0;
        frames_m = 0;
        @(negedge clk);
        chk("midreset_data_en", 32'(data_en), 32'(0));
        chk("midreset_busy", 32'(busy_o), 32'(0));
        chk("midreset_frame_cnt", 32'(frame_cnt_o), 32'(0));
        repeat (5) tick();
        chk("midreset_stays_idle", 32'(busy_o), 32'(0));
        run_frame(0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
